// File: rtl/afifo_rd_pack_if.sv
// afifo_rd_pack_if: packed-word valid/ready bundle.
// master drives the beat, slave returns out_rdy.
interface afifo_rd_pack_if #(
  parameter int DW   = 20,
  parameter int CNTW = 3
);
  logic [DW-1:0]   out_dat;
  logic [CNTW-1:0] out_cnt;
  logic            out_vld;
  logic            out_rdy;

  modport master (
    output out_dat,
    output out_cnt,
    output out_vld,
    input  out_rdy
  );

  modport slave (
    input  out_dat,
    input  out_cnt,
    input  out_vld,
    output out_rdy
  );
endinterface

// File: rtl/afifo_rd_pack.sv
// afifo_rd_pack: pops afifo words and packs PACK_NUM of them per beat.
// Define AFIFO_RD_PACK_STAT_EN to add stat_words/stat_packs counters.
module afifo_rd_pack #(
  parameter int BITWID   = 5,
  parameter int PACK_NUM = 4,
  parameter int CNTW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd,
  input  logic [BITWID-1:0] rd_dat,
  input  logic              rd_dat_vld,
  input  logic              flush,
  output logic              flush_done,
  output logic              err_unexp,
`ifdef AFIFO_RD_PACK_STAT_EN
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_packs,
`endif
  afifo_rd_pack_if.master   beat
);

  localparam int DW = PACK_NUM * BITWID;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FL_DRAIN = 2'd1;
  localparam logic [1:0] FL_XFER  = 2'd2;
  localparam logic [1:0] FL_DONE  = 2'd3;

  localparam logic [CNTW-1:0] FULL = CNTW'(PACK_NUM);
  localparam logic [CNTW:0]   LIM  = (CNTW+1)'(PACK_NUM);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CNTW-1:0] asm_cnt;
  logic [DW-1:0]   asm_dat;
  logic            pend;
  logic            full;
  logic            free;
  logic            xfer;
  logic            room;
  logic            store;
  logic [CNTW:0]   used;
  logic [CNTW-1:0] slot;

  assign full = asm_cnt == FULL;
  assign free = ~beat.out_vld | beat.out_rdy;
  assign xfer = free & (full |
                (state == FL_XFER && asm_cnt != '0));

  assign used = {1'b0, asm_cnt} + {{CNTW{1'b0}}, pend};

  // The last slot may be requested early when the output is free:
  // that word arrives exactly as the full pack leaves.
  assign room = (used < LIM) |
                ((used == LIM) & pend & free);

  assign rd = ~rst & ~empty & (state == RUN) & (room | xfer);

  assign slot  = xfer ? '0 : asm_cnt;
  assign store = rd_dat_vld & (xfer | ~full);

  assign flush_done = state == FL_DONE;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (flush) state_nxt = FL_DRAIN;
      FL_DRAIN: if (!pend) state_nxt = FL_XFER;
      FL_XFER:  if (asm_cnt == '0 || xfer)
                  state_nxt = FL_DONE;
      FL_DONE:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      asm_cnt      <= '0;
      asm_dat      <= '0;
      pend         <= 1'b0;
      err_unexp    <= 1'b0;
      beat.out_dat <= '0;
      beat.out_cnt <= '0;
      beat.out_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= rd;
      if (rd_dat_vld & ~pend) err_unexp <= 1'b1;
      if (xfer) begin
        beat.out_dat <= asm_dat;
        beat.out_cnt <= asm_cnt;
        beat.out_vld <= 1'b1;
        asm_dat      <= '0;
        asm_cnt      <= '0;
      end else if (beat.out_rdy) begin
        beat.out_vld <= 1'b0;
      end
      if (store) begin
        asm_dat[slot*BITWID +: BITWID] <= rd_dat;
        asm_cnt <= xfer ? CNTW'(1) : asm_cnt + CNTW'(1);
      end
    end
  end

`ifdef AFIFO_RD_PACK_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words <= '0;
      stat_packs <= '0;
    end else begin
      if (store) stat_words <= stat_words + 32'd1;
      if (beat.out_vld & beat.out_rdy)
        stat_packs <= stat_packs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_afifo_rd_pack.sv
// tb_afifo_rd_pack: word-stream model of afifo + consumer,
// directed packing/stall/flush/reset/error cases, then random traffic.
module tb_afifo_rd_pack;
  localparam int BW = 5;
  localparam int PN = 4;
  localparam int CW = 3;
  localparam int DW = PN * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          empty = 1'b1;
  logic          rd;
  logic [BW-1:0] rd_dat = '0;
  logic          rd_dat_vld = 1'b0;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          err_unexp;
`ifdef AFIFO_RD_PACK_STAT_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_packs;
`endif

  afifo_rd_pack_if #(.DW(DW), .CNTW(CW)) bi ();

  afifo_rd_pack #(
    .BITWID(BW), .PACK_NUM(PN), .CNTW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .empty(empty),
    .rd(rd),
    .rd_dat(rd_dat),
    .rd_dat_vld(rd_dat_vld),
    .flush(flush),
    .flush_done(flush_done),
    .err_unexp(err_unexp),
`ifdef AFIFO_RD_PACK_STAT_EN
    .stat_words(stat_words),
    .stat_packs(stat_packs),
`endif
    .beat(bi)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // afifo contents and stimulus helpers
  logic [BW-1:0] fq[$];
  logic          stall = 1'b0;
  logic          rd_now = 1'b0;
  logic          hs_now = 1'b0;

  task automatic cyc();
    @(negedge clk);
    rd_now = rd;
    hs_now = bi.out_vld & bi.out_rdy;
    @(posedge clk);
    #1;
    rd_dat_vld = rd_now;
    if (rd_now && fq.size() != 0) rd_dat = fq.pop_front();
    else rd_dat = BW'($urandom);
    empty = (fq.size() == 0) | stall;
  endtask

  task automatic push(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(BW'(base + i));
    empty = (fq.size() == 0) | stall;
  endtask

  // model: words taken by the DUT, in order
  logic [BW-1:0] got[$];
  logic [DW-1:0] blog_dat[$];
  int            blog_cnt[$];
  logic          p_rst = 1'b1;
  logic          p_rd = 1'b0;
  logic          p_vld = 1'b0;
  logic          p_rdy = 1'b0;
  logic [DW-1:0] p_dat = '0;
  logic [CW-1:0] p_cnt = '0;
  logic          flushing = 1'b0;
  logic          part_ok = 1'b0;
  logic          err_exp = 1'b0;
  int            fl_cyc = 0;
  logic          fd_seen = 1'b0;
  logic          fd_vld = 1'b0;
  logic [CW-1:0] fd_cnt = '0;

  always @(negedge clk) begin : cmp
    int left;
    int c;
    logic [DW-1:0] e;
    if (p_rst) begin
      chk("rst_vld", bi.out_vld, 0);
      chk("rst_dat", bi.out_dat, 0);
      chk("rst_cnt", bi.out_cnt, 0);
      chk("rst_fd", flush_done, 0);
      chk("rst_err", err_unexp, 0);
    end else begin
      if (rd) chk("rd_empty", empty, 0);
      if (flushing) chk("rd_flush", rd, 0);
      chk("err", err_unexp, err_exp);
      if (p_vld && !p_rdy) begin
        chk("hold_vld", bi.out_vld, 1);
        chk("hold_dat", bi.out_dat, p_dat);
        chk("hold_cnt", bi.out_cnt, p_cnt);
      end
      if (flush_done) begin
        chk("fd_state", flushing, 1);
        left = got.size() - (bi.out_vld ? int'(bi.out_cnt) : 0);
        chk("fd_left", left, 0);
        fd_seen = 1'b1;
        fd_vld = bi.out_vld;
        fd_cnt = bi.out_cnt;
      end
      if (bi.out_vld && bi.out_rdy && !rst) begin
        c = int'(bi.out_cnt);
        chk("beat_cnt_ok", (c >= 1 && c <= PN), 1);
        if (c < PN) chk("beat_part", part_ok, 1);
        chk("beat_avail", got.size() >= c, 1);
        e = '0;
        for (int k = 0; k < c && k < PN; k++)
          if (got.size() != 0) e[k*BW +: BW] = got.pop_front();
        chk("beat_dat", bi.out_dat, e);
        blog_dat.push_back(bi.out_dat);
        blog_cnt.push_back(c);
        if (!flushing) part_ok = 1'b0;
      end
    end
    if (rst) begin
      got.delete();
      flushing = 1'b0;
      part_ok = 1'b0;
      err_exp = 1'b0;
      fl_cyc = 0;
    end else begin
      if (rd_dat_vld) begin
        if (!p_rd) err_exp = 1'b1;
        got.push_back(rd_dat);
      end
      if (flushing) begin
        fl_cyc++;
        if (flush_done) flushing = 1'b0;
        else if (fl_cyc > 400) begin
          chk("flush_to", 0, 1);
          flushing = 1'b0;
        end
      end else if (flush) begin
        flushing = 1'b1;
        part_ok = 1'b1;
        fl_cyc = 0;
      end
    end
    p_rst = rst;
    p_rd = rd;
    p_vld = bi.out_vld;
    p_rdy = bi.out_rdy;
    p_dat = bi.out_dat;
    p_cnt = bi.out_cnt;
  end

  task automatic do_flush();
    fd_seen = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 400 && !fd_seen; i++) cyc();
    chk("flush_done", fd_seen, 1);
    cyc();
  endtask

  task automatic clr_log();
    blog_dat.delete();
    blog_cnt.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin : drv
    int rd_hi;
    int hs;
    bi.out_rdy = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // 8 words -> two full beats
    clr_log();
    push(1, 8);
    repeat (16) cyc();
    chk("t1_nbeats", blog_dat.size(), 2);
    if (blog_dat.size() == 2) begin
      chk("t1_b0", blog_dat[0], 20'h20C41);
      chk("t1_c0", blog_cnt[0], 4);
      chk("t1_b1", blog_dat[1], 20'h41CC5);
      chk("t1_c1", blog_cnt[1], 4);
    end
    chk("t1_rd_idle", rd, 0);
`ifdef AFIFO_RD_PACK_STAT_EN
    chk("stat_words", stat_words, 8);
    chk("stat_packs", stat_packs, 2);
`endif

    // continuous supply, ready consumer
    push(0, 40);
    repeat (6) cyc();
    rd_hi = 0;
    hs = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      rd_hi += int'(rd_now);
      hs += int'(hs_now);
    end
    chk("fr_rd_hi", rd_hi, 24);
    chk("fr_beats", hs, 6);
    repeat (20) cyc();
    do_flush();

    // output stalled with 12 words available
    clr_log();
    bi.out_rdy = 1'b0;
    push(10, 12);
    repeat (20) cyc();
    chk("st_rd", rd, 0);
    chk("st_vld", bi.out_vld, 1);
    chk("st_cnt", bi.out_cnt, 4);
    chk("st_dat", bi.out_dat, 20'h6B16A);
    bi.out_rdy = 1'b1;
    repeat (20) cyc();
    chk("st_nbeats", blog_dat.size(), 3);

    // partial flush of 3 words, then empty flush
    clr_log();
    push(9, 3);
    repeat (8) cyc();
    do_flush();
    chk("fl_nbeats", blog_dat.size(), 1);
    if (blog_dat.size() == 1) begin
      chk("fl_dat", blog_dat[0], 20'h02D49);
      chk("fl_cnt", blog_cnt[0], 3);
    end
    chk("fl_fd_vld", fd_vld, 1);
    chk("fl_fd_cnt", fd_cnt, 3);
    clr_log();
    do_flush();
    chk("fl0_nbeats", blog_dat.size(), 0);
    chk("fl0_fd_vld", fd_vld, 0);

    // reset with two words assembled and one in flight
    clr_log();
    push(20, 8);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (12) cyc();
    chk("rs_nbeats", blog_dat.size(), 1);
    if (blog_dat.size() != 0)
      chk("rs_dat", blog_dat[0], 20'hD6717);
    do_flush();

    // data valid with no read pending
    clr_log();
    cyc();
    rd_dat_vld = 1'b1;
    rd_dat = 5'd5;
    cyc();
    repeat (3) cyc();
    chk("err_set", err_unexp, 1);
    do_flush();
    chk("err_sticky", err_unexp, 1);
    chk("err_nbeats", blog_dat.size(), 1);
    if (blog_dat.size() == 1) begin
      chk("err_dat", blog_dat[0], 20'h00005);
      chk("err_cnt", blog_cnt[0], 1);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("err_clr", err_unexp, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16)
        fq.push_back(BW'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      bi.out_rdy = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 599) == 0);
      empty = (fq.size() == 0) | stall;
      cyc();
    end
    flush = 1'b0;
    rst = 1'b0;
    stall = 1'b0;
    bi.out_rdy = 1'b1;
    empty = (fq.size() == 0);
    repeat (40) cyc();
    do_flush();
    cyc();
    chk("end_got", got.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
